bcd_serial_adder: RTL

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_adder.sv | 119 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Holds the controller state encoding and decimal digit limits.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder with +6 correction.
// Flags operand digits outside 0..9 but still applies the correction.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci,
   output logic [3:0] digit,
   output logic       co,
   output logic       bad
);

   logic [4:0] raw;

   // Binary sum, then decimal correction when it passes nine.
   always_comb begin
      raw   = {1'b0, a_i} + {1'b0, b_i} + {4'b0, ci};
      co    = (raw > {1'b0, BCD_MAX});
      digit = co ? (raw[3:0] + BCD_CORR) : raw[3:0];
      bad   = (a_i > BCD_MAX) | (b_i > BCD_MAX);
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock, LSD first.
// Results are committed only when the last digit is processed.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   input  logic              cin,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] s,
   output logic              cout,
   output logic              err
);

   localparam int W  = 4 * NDIG;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t state;
   state_t nxt;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-5:0]  r_sh;
   logic [W-1:0]  cat;
   logic [CW-1:0] cnt;
   logic          carry;
   logic          err_acc;
   logic          last;
   logic [3:0]    dig;
   logic          co;
   logic          bad;

   bcd_digit_add u_dig (
      .a_i   (a_sh[3:0]),
      .b_i   (b_sh[3:0]),
      .ci    (carry),
      .digit (dig),
      .co    (co),
      .bad   (bad)
   );

   assign last = (cnt == CW'(NDIG - 1));
   assign cat  = {dig, r_sh};

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state logic and status outputs.
   always_comb begin
      nxt  = state;
      busy = 1'b1;
      done = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) nxt = ADD;
         end
         ADD: begin
            if (last) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Operand/result shifting and end-of-add commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         err_acc <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
         err     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry   <= cin;
                  cnt     <= '0;
                  err_acc <= 1'b0;
               end
            end
            ADD: begin
               a_sh    <= a_sh >> 4;
               b_sh    <= b_sh >> 4;
               r_sh    <= cat[W-1:4];
               carry   <= co;
               err_acc <= err_acc | bad;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  s    <= cat;
                  cout <= co;
                  err  <= err_acc | bad;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
